// File: rtl/btb_pkg.sv
// Shared types, default geometry and PC field helpers for the associative BTB.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package btb_pkg;
    localparam int BTB_ADDR_W    = 32;
    localparam int BTB_SETS_LOG2 = 4;
    localparam int BTB_WAYS      = 2;
    localparam int BTB_TAG_W     = BTB_ADDR_W - BTB_SETS_LOG2 - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RESPOND = 2'd2
    } btb_state_t;

    // Set index: the word-aligned PC bits directly above the byte offset.
    function automatic logic [BTB_SETS_LOG2-1:0] btb_index(input logic [BTB_ADDR_W-1:0] pc);
        return BTB_SETS_LOG2'(pc >> 2);
    endfunction

    // Tag: every PC bit above the set index.
    function automatic logic [BTB_TAG_W-1:0] btb_tag(input logic [BTB_ADDR_W-1:0] pc);
        return BTB_TAG_W'(pc >> (BTB_SETS_LOG2 + 2));
    endfunction
endpackage

// File: rtl/btb_assoc_ctrl_if.sv
// Lookup, update and flush signals between fetch/EX (master) and the BTB (slave).
// Latency: n/a (wiring only); BTB_STATS_EN adds the hit/miss counter outputs.
// Backpressure: write is held by the master until resp pulses; lookups never stall.
interface btb_assoc_ctrl_if import btb_pkg::*; #(
    parameter int ADDR_W = BTB_ADDR_W
);
    logic              lookup_valid;
    logic [ADDR_W-1:0] lookup_pc;
    logic              lookup_resp;
    logic              hit;
    logic [ADDR_W-1:0] target;
    logic              write;
    logic [ADDR_W-1:0] write_pc;
    logic [ADDR_W-1:0] write_target;
    logic              resp;
    logic              flush;
`ifdef BTB_STATS_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif

    modport master (
        output lookup_valid, lookup_pc, write, write_pc, write_target, flush,
        input  lookup_resp, hit, target, resp
`ifdef BTB_STATS_EN
        , input hit_count, miss_count
`endif
    );

    modport slave (
        input  lookup_valid, lookup_pc, write, write_pc, write_target, flush,
        output lookup_resp, hit, target, resp
`ifdef BTB_STATS_EN
        , output hit_count, miss_count
`endif
    );
endinterface

// File: rtl/btb_replace.sv
// Per-set round-robin pointers and the tag-hit / first-invalid / pointer way choice.
// Latency: way select is combinational; the pointer moves at the commit edge.
// Backpressure: none; the owner decides when an update commits.
module btb_replace import btb_pkg::*; #(
    parameter int SETS_LOG2 = BTB_SETS_LOG2,
    parameter int WAYS      = BTB_WAYS,
    parameter int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SETS_LOG2-1:0] set_idx,
    input  logic [WAYS-1:0]      match,
    input  logic [WAYS-1:0]      valid,
    input  logic                 commit,
    output logic [WAY_W-1:0]     way_sel,
    output logic                 ptr_adv
);
    localparam int SETS = 1 << SETS_LOG2;

    logic [WAY_W-1:0] cur_ptr;

    if (WAYS > 1) begin : g_rr
        logic [WAY_W-1:0] ptr_q [SETS];
        logic [WAY_W-1:0] ptr_d [SETS];

        // Advance only the written set's pointer, and only when it chose the victim.
        always_comb begin
            ptr_d = ptr_q;
            if (commit && ptr_adv) begin
                ptr_d[set_idx] = ptr_q[set_idx] + WAY_W'(1);
            end
        end

        // Pointer registers; power-of-two WAYS makes the wrap free.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end

        assign cur_ptr = ptr_q[set_idx];
    end else begin : g_dm
        assign cur_ptr = '0;
    end

    // Priority: matching way, else lowest invalid way, else round-robin victim.
    always_comb begin
        way_sel = cur_ptr;
        ptr_adv = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                way_sel = WAY_W'(w);
                ptr_adv = 1'b0;
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                way_sel = WAY_W'(w);
                ptr_adv = 1'b0;
            end
        end
    end
endmodule

// File: rtl/btb_assoc_ctrl.sv
// Set-associative BTB: pipelined lookups plus a write/resp update FSM with flush (stats under BTB_STATS_EN).
// Latency: lookup 1 cycle; write raised in cycle N gets resp in cycle N+2.
// Backpressure: lookups accepted every cycle; write must be held until resp.
module btb_assoc_ctrl import btb_pkg::*; #(
    parameter int ADDR_W    = BTB_ADDR_W,
    parameter int SETS_LOG2 = BTB_SETS_LOG2,
    parameter int WAYS      = BTB_WAYS
) (
    input  logic        clk,
    input  logic        rst,
    btb_assoc_ctrl_if.slave bus
);
    localparam int SETS  = 1 << SETS_LOG2;
    localparam int TAG_W = ADDR_W - SETS_LOG2 - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
    logic [ADDR_W-1:0] tgt_q   [SETS][WAYS];
    logic [ADDR_W-1:0] tgt_d   [SETS][WAYS];

    btb_state_t        state_q;
    logic              resp_q;
    logic              lookup_resp_q, lookup_resp_d;
    logic              hit_q, hit_d;
    logic [ADDR_W-1:0] target_q, target_d;

    logic [SETS_LOG2-1:0] lk_idx, wr_idx;
    logic [TAG_W-1:0]     lk_tag, wr_tag;
    logic [WAYS-1:0]      wr_match;
    logic [WAY_W-1:0]     way_sel;
    logic                 ptr_adv;
    logic                 wr_commit;

    assign lk_idx    = SETS_LOG2'(bus.lookup_pc >> 2);
    assign lk_tag    = TAG_W'(bus.lookup_pc >> (SETS_LOG2 + 2));
    assign wr_idx    = SETS_LOG2'(bus.write_pc >> 2);
    assign wr_tag    = TAG_W'(bus.write_pc >> (SETS_LOG2 + 2));
    assign wr_commit = (state_q == WRITE);

    // Tag compare of the pending update against its set, feeding the way chooser.
    always_comb begin
        wr_match = '0;
        for (int w = 0; w < WAYS; w++) begin
            wr_match[w] = valid_q[wr_idx][w] && (tag_q[wr_idx][w] == wr_tag);
        end
    end

    btb_replace #(
        .SETS_LOG2 (SETS_LOG2),
        .WAYS      (WAYS),
        .WAY_W     (WAY_W)
    ) u_replace (
        .clk     (clk),
        .rst     (rst),
        .set_idx (wr_idx),
        .match   (wr_match),
        .valid   (valid_q[wr_idx]),
        .commit  (wr_commit),
        .way_sel (way_sel),
        .ptr_adv (ptr_adv)
    );

    // Lookup reads pre-edge array state, so a same-edge commit or flush is not seen.
    always_comb begin
        lookup_resp_d = bus.lookup_valid;
        hit_d         = 1'b0;
        target_d      = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (bus.lookup_valid && valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                hit_d    = 1'b1;
                target_d = tgt_q[lk_idx][w];
            end
        end
    end

    // Lookup response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lookup_resp_q <= 1'b0;
            hit_q         <= 1'b0;
            target_q      <= '0;
        end else begin
            lookup_resp_q <= lookup_resp_d;
            hit_q         <= hit_d;
            target_q      <= target_d;
        end
    end

    // Array next state: the commit goes in first so a coincident flush overrides it.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        if (wr_commit) begin
            valid_d[wr_idx][way_sel] = 1'b1;
            tag_d[wr_idx][way_sel]   = wr_tag;
            tgt_d[wr_idx][way_sel]   = bus.write_target;
        end
        if (bus.flush) begin
            for (int s = 0; s < SETS; s++) valid_d[s] = '0;
        end
    end

    // Valid bits reset; a reset on the commit edge therefore discards the update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and target storage carries no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

    // Update FSM with registered resp, high exactly during RESPOND.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            resp_q  <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE:    if (bus.write) state_q <= WRITE;
                WRITE: begin
                    state_q <= RESPOND;
                    resp_q  <= 1'b1;
                end
                RESPOND: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.lookup_resp = lookup_resp_q;
    assign bus.hit         = hit_q;
    assign bus.target      = target_q;
    assign bus.resp        = resp_q;

`ifdef BTB_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Count each delivered lookup response, saturating at all-ones.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (lookup_resp_q) begin
            if (hit_q) begin
                if (hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
            end else begin
                if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
            end
        end
    end

    // Counters clear on reset only; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_btb_assoc_ctrl.sv
// Directed plus randomized bench for btb_assoc_ctrl against a table-based reference model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: bench holds write until resp, as a well-behaved master would.
module tb_btb_assoc_ctrl;
    localparam int SETS = 16;
    localparam int WAYS = 2;

    logic clk;
    logic rst;

    btb_assoc_ctrl_if #(.ADDR_W(32)) bif ();

    btb_assoc_ctrl #(.ADDR_W(32), .SETS_LOG2(4), .WAYS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    // Reference model: per set, WAYS slots of {valid, tag, target} and a victim pointer.
    bit          m_valid [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    logic [31:0] m_tgt   [SETS][WAYS];
    int          m_ptr   [SETS];

    function automatic int unsigned f_set(input logic [31:0] pc);
        return (pc / 4) % SETS;
    endfunction

    function automatic int unsigned f_tag(input logic [31:0] pc);
        return pc / (4 * SETS);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
        end
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
    endfunction

    function automatic void model_write(input logic [31:0] pc, input logic [31:0] tgt);
        int unsigned s = f_set(pc);
        int unsigned t = f_tag(pc);
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                m_tgt[s][w] = tgt;
                return;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!m_valid[s][w]) begin
                m_valid[s][w] = 1; m_tag[s][w] = t; m_tgt[s][w] = tgt;
                return;
            end
        end
        m_valid[s][m_ptr[s]] = 1;
        m_tag[s][m_ptr[s]]   = t;
        m_tgt[s][m_ptr[s]]   = tgt;
        m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output bit h, output logic [31:0] tgt);
        int unsigned s = f_set(pc);
        int unsigned t = f_tag(pc);
        h = 0; tgt = 32'h0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                h = 1; tgt = m_tgt[s][w];
            end
        end
    endfunction

    function automatic logic [31:0] pick_pc();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0: t = 32'h0;
            1: t = 32'h1;
            2: t = 32'h2;
            default: t = 32'h03FF_FFFF;
        endcase
        return (t << 6) | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input logic [31:0] pc, input string nm);
        bit eh;
        logic [31:0] et;
        model_lookup(pc, eh, et);
        bif.lookup_valid = 1'b1;
        bif.lookup_pc    = pc;
        tick();
        bif.lookup_valid = 1'b0;
        chk({nm, "_resp"}, 32'(bif.lookup_resp), 32'd1);
        chk({nm, "_hit"},  32'(bif.hit), 32'(eh));
        chk({nm, "_tgt"},  bif.target, et);
        if (eh) exp_hits++; else exp_miss++;
    endtask

    // One update transaction; optional flush and/or lookup of the same PC on the commit edge.
    task automatic do_write(input logic [31:0] pc, input logic [31:0] tgt,
                            input bit fl, input bit lk, input string nm);
        bit eh;
        logic [31:0] et;
        bif.write        = 1'b1;
        bif.write_pc     = pc;
        bif.write_target = tgt;
        chk({nm, "_resp_n"}, 32'(bif.resp), 32'd0);
        tick();
        chk({nm, "_resp_n1"}, 32'(bif.resp), 32'd0);
        if (fl) bif.flush = 1'b1;
        if (lk) begin
            model_lookup(pc, eh, et);
            bif.lookup_valid = 1'b1;
            bif.lookup_pc    = pc;
        end
        tick();
        bif.flush        = 1'b0;
        bif.write        = 1'b0;
        bif.lookup_valid = 1'b0;
        model_write(pc, tgt);
        if (fl) model_flush();
        chk({nm, "_resp_n2"}, 32'(bif.resp), 32'd1);
        if (lk) begin
            chk({nm, "_lk_hit"}, 32'(bif.hit), 32'(eh));
            chk({nm, "_lk_tgt"}, bif.target, et);
            if (eh) exp_hits++; else exp_miss++;
        end
        tick();
        chk({nm, "_resp_n3"}, 32'(bif.resp), 32'd0);
    endtask

    initial begin
        bit          lv, fl, eh;
        logic [31:0] lpc, et, wpc, wtgt;
        int          wphase;
        bit          commit_now;

        rst = 1'b1;
        bif.lookup_valid = 1'b0; bif.lookup_pc = '0;
        bif.write = 1'b0; bif.write_pc = '0; bif.write_target = '0;
        bif.flush = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        chk("rst_lookup_resp", 32'(bif.lookup_resp), 32'd0);
        chk("rst_hit",         32'(bif.hit), 32'd0);
        chk("rst_target",      bif.target, 32'd0);
        chk("rst_resp",        32'(bif.resp), 32'd0);

        do_lookup(32'h0000_1000, "cold");
        do_write(32'h1000, 32'h2000, 0, 0, "w1000");
        do_lookup(32'h1000, "after_w1000");
        chk("after_w1000_const_tgt", bif.target, 32'h2000);

        do_write(32'h1040, 32'h4040, 0, 0, "w1040");
        do_write(32'h1080, 32'h4080, 0, 0, "w1080");
        do_lookup(32'h1000, "evict_1000");
        do_lookup(32'h1040, "keep_1040");
        do_lookup(32'h1080, "keep_1080");

        do_write(32'h1040, 32'h3000, 0, 0, "rw1040");
        do_lookup(32'h1040, "rw_1040");
        chk("rw_1040_const_tgt", bif.target, 32'h3000);
        do_lookup(32'h1080, "rw_1080");

        do_write(32'h1000, 32'h2222, 0, 1, "w1000_samedge");
        do_lookup(32'h1000, "next_1000");
        do_lookup(32'h1040, "victim_1040");
        do_lookup(32'h1080, "kept_1080");

        bif.flush = 1'b1; tick(); bif.flush = 1'b0; model_flush();
        do_lookup(32'h1000, "fl_1000");
        do_lookup(32'h1040, "fl_1040");
        do_lookup(32'h1080, "fl_1080");

        do_write(32'h1100, 32'h7777, 1, 0, "w_flush_commit");
        do_lookup(32'h1100, "fc_1100");

        bif.write = 1'b1; bif.write_pc = 32'h2000; bif.write_target = 32'h5000;
        tick();
        rst = 1'b1; bif.write = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        exp_hits = 0; exp_miss = 0;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_resp", 32'(bif.resp), 32'd0);
            tick();
        end
        do_lookup(32'h2000, "midrst_2000");

        wphase = 0;
        wpc = '0; wtgt = '0;
        for (int c = 0; c < 400; c++) begin
            lv  = ($urandom_range(0, 1) == 1);
            lpc = pick_pc();
            eh  = 0; et = '0;
            if (lv) model_lookup(lpc, eh, et);
            fl = ($urandom_range(0, 15) == 0);
            if (wphase == 0 && $urandom_range(0, 2) == 0) begin
                wpc  = pick_pc();
                wtgt = $urandom;
                bif.write = 1'b1; bif.write_pc = wpc; bif.write_target = wtgt;
                wphase = 1;
            end else if (wphase == 3) begin
                bif.write = 1'b0;
            end
            bif.lookup_valid = lv;
            bif.lookup_pc    = lpc;
            bif.flush        = fl;
            commit_now = (wphase == 2);
            tick();
            if (commit_now) model_write(wpc, wtgt);
            if (fl) model_flush();
            if (wphase == 3) wphase = 0;
            else if (wphase != 0) wphase = wphase + 1;
            chk("rnd_lookup_resp", 32'(bif.lookup_resp), 32'(lv));
            chk("rnd_hit",         32'(bif.hit), 32'(eh));
            chk("rnd_target",      bif.target, et);
            chk("rnd_resp",        32'(bif.resp), 32'(wphase == 3));
            if (lv) begin
                if (eh) exp_hits++; else exp_miss++;
            end
        end
        bif.lookup_valid = 1'b0; bif.flush = 1'b0;
        if (wphase != 0) begin
            bif.write = 1'b0;
            repeat (3) tick();
        end
        tick(); tick();

`ifdef BTB_STATS_EN
        chk("stats_hit_count",  bif.hit_count,  32'(exp_hits));
        chk("stats_miss_count", bif.miss_count, 32'(exp_miss));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
